// File: rtl/alu_pkg.sv
// Shared ALU definitions: data widths, opcode set and sweep-driver FSM states.
// Used by alu_sweep_driver (optional macro ALU_SWEEP_SIGNATURE_EN lives there).
package alu_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int SEL_W_DEF = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADC  = 4'd1,
      OP_SUB  = 4'd2,
      OP_SBB  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_ROL  = 4'd10,
      OP_ROR  = 4'd11,
      OP_INC  = 4'd12,
      OP_DEC  = 4'd13,
      OP_PASA = 4'd14,
      OP_PASB = 4'd15
   } alu_op_e;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t DRIVE = 2'd1;
   localparam state_t RESP  = 2'd2;

endpackage

// File: rtl/alu_sweep_driver.sv
// Drives one operand pair through NUM_OPS consecutive ALU opcodes, one record each.
// Define ALU_SWEEP_SIGNATURE_EN to add the sig/sig_carry result fold outputs.
module alu_sweep_driver
   import alu_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int SEL_W     = SEL_W_DEF,
   parameter int FIRST_SEL = 1,
   parameter int NUM_OPS   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic [SEL_W-1:0] res_sel,
   output logic             res_last,
   output logic             busy
`ifdef ALU_SWEEP_SIGNATURE_EN
   ,
   output logic [WIDTH-1:0] sig,
   output logic             sig_carry
`endif
);

   localparam int CNT_W = $clog2(NUM_OPS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);
   localparam logic [SEL_W-1:0] SEL0 = SEL_W'(FIRST_SEL);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cmd_fire;
   logic             res_fire;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign res_fire  = res_valid && res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
         res_sel   <= '0;
         res_last  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_fire) begin
                  alu_a   <= cmd_a;
                  alu_b   <= cmd_b;
                  alu_sel <= SEL0;
                  cnt     <= '0;
                  state   <= DRIVE;
               end
            end
            // ALU output has settled from the operands registered last edge
            DRIVE: begin
               res_data  <= alu_out;
               res_carry <= alu_carry;
               res_sel   <= alu_sel;
               res_last  <= (cnt == LAST_CNT);
               res_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (res_fire) begin
                  res_valid <= 1'b0;
                  if (res_last) begin
                     state <= IDLE;
                  end else begin
                     alu_sel <= alu_sel + 1'b1;
                     cnt     <= cnt + 1'b1;
                     state   <= DRIVE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SWEEP_SIGNATURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig       <= '0;
         sig_carry <= 1'b0;
      end else if (cmd_fire) begin
         sig       <= '0;
         sig_carry <= 1'b0;
      end else if (res_fire) begin
         sig       <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ res_data;
         sig_carry <= sig_carry ^ res_carry;
      end
   end
`endif

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: transaction model plus directed literal checks.
// Three instances: defaults, a wrapping FIRST_SEL=14 sweep, and NUM_OPS=1.
`timescale 1ns/1ps
module tb_alu_sweep_driver;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic [3:0] s;
      logic       l;
      int         t;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cmd_valid = 1'b0;
   logic       res_ready = 1'b1;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;

   int checks = 0;
   int errs = 0;
   int cyc = 0;

   // default instance
   logic       cmd_ready, busy, res_valid, res_carry, res_last, alu_carry;
   logic [7:0] alu_a, alu_b, alu_out, res_data;
   logic [3:0] alu_sel, res_sel;
   assign {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {5'b0, alu_sel};

   // wrap instance
   logic       w_cmd_ready, w_busy, w_res_valid, w_res_carry, w_res_last, w_alu_carry;
   logic [7:0] w_alu_a, w_alu_b, w_alu_out, w_res_data;
   logic [3:0] w_alu_sel, w_res_sel;
   assign {w_alu_carry, w_alu_out} = {1'b0, w_alu_a} + {1'b0, w_alu_b} + {5'b0, w_alu_sel};

   // single-op instance
   logic       n_cmd_ready, n_busy, n_res_valid, n_res_carry, n_res_last, n_alu_carry;
   logic [7:0] n_alu_a, n_alu_b, n_alu_out, n_res_data;
   logic [3:0] n_alu_sel, n_res_sel;
   assign {n_alu_carry, n_alu_out} = {1'b0, n_alu_a} + {1'b0, n_alu_b} + {5'b0, n_alu_sel};

`ifdef ALU_SWEEP_SIGNATURE_EN
   logic [7:0] sig, w_sig, n_sig;
   logic       sig_carry, w_sig_carry, n_sig_carry;
`endif

   alu_sweep_driver u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry),
      .res_sel(res_sel), .res_last(res_last), .busy(busy)
`ifdef ALU_SWEEP_SIGNATURE_EN
      , .sig(sig), .sig_carry(sig_carry)
`endif
   );

   alu_sweep_driver #(.FIRST_SEL(14), .NUM_OPS(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel),
      .alu_out(w_alu_out), .alu_carry(w_alu_carry), .res_valid(w_res_valid),
      .res_ready(res_ready), .res_data(w_res_data), .res_carry(w_res_carry),
      .res_sel(w_res_sel), .res_last(w_res_last), .busy(w_busy)
`ifdef ALU_SWEEP_SIGNATURE_EN
      , .sig(w_sig), .sig_carry(w_sig_carry)
`endif
   );

   alu_sweep_driver #(.FIRST_SEL(3), .NUM_OPS(1)) u_one (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_sel(n_alu_sel),
      .alu_out(n_alu_out), .alu_carry(n_alu_carry), .res_valid(n_res_valid),
      .res_ready(res_ready), .res_data(n_res_data), .res_carry(n_res_carry),
      .res_sel(n_res_sel), .res_last(n_res_last), .busy(n_busy)
`ifdef ALU_SWEEP_SIGNATURE_EN
      , .sig(n_sig), .sig_carry(n_sig_carry)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // expected record k of a sweep with bench ALU out = A + B + sel
   function automatic rec_t mk(input logic [7:0] a, input logic [7:0] b,
                               input int k, input int first, input int n);
      rec_t r;
      int   sum;
      r.s = 4'((first + k) % 16);
      sum = int'(a) + int'(b) + int'(r.s);
      r.d = 8'(sum);
      r.c = (sum > 255);
      r.l = (k == n - 1);
      r.t = 0;
      return r;
   endfunction

   // transaction model of the default instance
   rec_t       q[$];
   rec_t       pr;
   bit         m_idle = 1'b1;
   bit         m_valid = 1'b0;
   bit         m_arm = 1'b0;
   bit         acc;
   logic [7:0] m_a = '0;
   logic [7:0] m_b = '0;
   logic [3:0] m_sel = '0;
   logic [7:0] m_sig = '0;
   logic       m_sigc = 1'b0;
   int         n_acc = 0;
   int         acc_cyc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_idle = 1'b1; m_valid = 1'b0; m_arm = 1'b0;
         m_a = '0; m_b = '0; m_sel = '0; m_sig = '0; m_sigc = 1'b0;
      end else begin
         acc = m_idle && cmd_valid;
         if (m_valid) begin
            if (res_ready) begin
               pr = q.pop_front();
               m_sel = pr.s;
               m_sig = {m_sig[6:0], m_sig[7]} ^ pr.d;
               m_sigc = m_sigc ^ pr.c;
               m_valid = 1'b0;
               if (q.size() == 0) m_idle = 1'b1;
               else m_arm = 1'b1;
            end
         end else if (m_arm) begin
            m_arm = 1'b0;
            m_valid = 1'b1;
         end
         if (acc) begin
            m_a = cmd_a; m_b = cmd_b;
            for (int k = 0; k < 4; k++) q.push_back(mk(cmd_a, cmd_b, k, 1, 4));
            m_idle = 1'b0; m_arm = 1'b1;
            m_sig = '0; m_sigc = 1'b0;
            n_acc++;
            acc_cyc = cyc;
         end
         cyc++;
      end
   end

   rec_t log0[$];
   rec_t log1[$];
   rec_t log2[$];

   always @(negedge clk) begin
      if (rst_n) begin
         chk("res_valid", res_valid, m_valid);
         chk("cmd_ready", cmd_ready, m_idle);
         chk("busy", busy, !m_idle);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_sel", alu_sel, (q.size() != 0) ? q[0].s : m_sel);
         if (m_valid) begin
            chk("res_data", res_data, q[0].d);
            chk("res_carry", res_carry, q[0].c);
            chk("res_sel", res_sel, q[0].s);
            chk("res_last", res_last, q[0].l);
         end
`ifdef ALU_SWEEP_SIGNATURE_EN
         if (m_idle) begin
            chk("sig", sig, m_sig);
            chk("sig_carry", sig_carry, m_sigc);
         end
`endif
         if (res_valid && res_ready)
            log0.push_back('{res_data, res_carry, res_sel, res_last, cyc});
         if (w_res_valid && res_ready)
            log1.push_back('{w_res_data, w_res_carry, w_res_sel, w_res_last, cyc});
         if (n_res_valid && res_ready)
            log2.push_back('{n_res_data, n_res_carry, n_res_sel, n_res_last, cyc});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b);
      int n0;
      int t;
      n0 = n_acc;
      t = 0;
      cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      while (n_acc == n0 && t < 50) begin
         step(1);
         t++;
      end
      cmd_valid = 1'b0;
      if (n_acc == n0) chk("send_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 200) begin
         step(1);
         t++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic wait_rec(input int n);
      int t;
      t = 0;
      while (!(res_valid && log0.size() == n) && t < 50) begin
         step(1);
         t++;
      end
      if (!res_valid) chk("rec_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      step(3);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step(1);
      chk("rel_cmd_ready", cmd_ready, 1);

      // sweep of A=05 B=04
      log0.delete(); log1.delete(); log2.delete();
      send(8'h05, 8'h04);
      wait_idle();
      chk("c1_count", log0.size(), 4);
      if (log0.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("c1_data", log0[i].d, 32'h0A + i);
            chk("c1_sel", log0[i].s, 1 + i);
            chk("c1_carry", log0[i].c, 0);
            chk("c1_last", log0[i].l, (i == 3) ? 1 : 0);
         end
         chk("c1_latency", log0[0].t - acc_cyc, 2);
         for (int i = 1; i < 4; i++) chk("c1_spacing", log0[i].t - log0[i-1].t, 2);
      end
`ifdef ALU_SWEEP_SIGNATURE_EN
      chk("c1_sig", sig, 8'h69);
      chk("c1_sig_carry", sig_carry, 0);
`endif
      step(4);
      chk("wrap_count", log1.size(), 4);
      if (log1.size() == 4) begin
         chk("wrap_sel0", log1[0].s, 14);
         chk("wrap_sel1", log1[1].s, 15);
         chk("wrap_sel2", log1[2].s, 0);
         chk("wrap_sel3", log1[3].s, 1);
         chk("wrap_data2", log1[2].d, 8'h09);
         chk("wrap_last2", log1[2].l, 0);
         chk("wrap_last3", log1[3].l, 1);
      end
      chk("one_count", log2.size(), 1);
      if (log2.size() >= 1) begin
         chk("one_sel", log2[0].s, 3);
         chk("one_data", log2[0].d, 8'h0C);
         chk("one_last", log2[0].l, 1);
      end

      // carry on every record
      log0.delete();
      send(8'hFF, 8'h01);
      wait_idle();
      chk("c2_count", log0.size(), 4);
      if (log0.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("c2_data", log0[i].d, 1 + i);
            chk("c2_carry", log0[i].c, 1);
         end
      end

      // backpressure on record 2
      log0.delete();
      send(8'h10, 8'h20);
      wait_rec(1);
      res_ready = 1'b0;
      step(5);
      chk("bp_data", res_data, 8'h32);
      chk("bp_sel", res_sel, 2);
      chk("bp_alu_sel", alu_sel, 2);
      chk("bp_valid", res_valid, 1);
      res_ready = 1'b1;
      wait_idle();
      chk("bp_count", log0.size(), 4);
      if (log0.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("bp_rec_sel", log0[i].s, 1 + i);
            chk("bp_rec_data", log0[i].d, 32'h31 + i);
         end
      end

      // command held across a sweep
      log0.delete();
      begin
         int n0;
         int t;
         n0 = n_acc;
         t = 0;
         cmd_a = 8'h01; cmd_b = 8'h02; cmd_valid = 1'b1;
         while (n_acc < n0 + 2 && t < 100) begin
            step(1);
            t++;
         end
         cmd_valid = 1'b0;
         chk("held_accepts", n_acc - n0, 2);
      end
      chk("held_first_sweep", log0.size(), 4);
      if (log0.size() == 4) begin
         chk("held_last", log0[3].l, 1);
         chk("held_gap", acc_cyc - log0[3].t, 1);
      end
      wait_idle();

      // reset while record 3 is offered
      log0.delete();
      send(8'h05, 8'h04);
      wait_rec(2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_res_valid", res_valid, 0);
      chk("ar_res_data", res_data, 0);
      chk("ar_res_sel", res_sel, 0);
      chk("ar_res_carry", res_carry, 0);
      chk("ar_res_last", res_last, 0);
      chk("ar_alu_a", alu_a, 0);
      chk("ar_alu_b", alu_b, 0);
      chk("ar_alu_sel", alu_sel, 0);
      chk("ar_busy", busy, 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("ar_cmd_ready", cmd_ready, 1);
      log0.delete();
      send(8'h05, 8'h04);
      wait_idle();
      chk("ar_count", log0.size(), 4);
      if (log0.size() >= 1) chk("ar_first_sel", log0[0].s, 1);

      step(2);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
